// File: rtl/cart_map_pkg.sv
// Shared definitions for the cartridge mapper arbiter: FSM states, channel indices, turbo policy default.
// Optional sticky multi-hot detection is enabled by defining CART_MAP_ERR_EN.
package cart_map_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_DRAIN  = 2'd3
    } cart_map_state_e;

    localparam int CH_DLH     = 0;
    localparam int CH_CX4     = 1;
    localparam int CH_SDD1    = 2;
    localparam int CH_GSU     = 3;
    localparam int CH_SA1     = 4;
    localparam int CH_SPC7110 = 5;
    localparam int CH_BSX     = 6;

    localparam logic [15:0] NO_TURBO_MASK_DEF = 16'h000A;

endpackage

// File: rtl/cart_map_onehot_dec.sv
// Combinational decoder for the mapper-present vector: index of a set bit,
// "any bit set" and "more than one bit set" flags.
module cart_map_onehot_dec #(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] i_vec,
    output logic [3:0]        o_idx,
    output logic              o_any,
    output logic              o_multi
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_idx   = '0;
        o_any   = 1'b0;
        o_multi = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_vec[i]) begin
                if (o_any) o_multi = 1'b1;
                o_any = 1'b1;
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/cart_map_arbiter.sv
// Debounced, bus-idle-switched selector of one mapper channel onto the shared ROM/BSRAM/CPU bus.
// Define CART_MAP_ERR_EN to enable the sticky map_err multi-hot/zero flag.
module cart_map_arbiter
    import cart_map_pkg::*;
#(
    parameter int          NUM_CH        = 8,
    parameter int          DEFAULT_CH    = CH_DLH,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          ROM_AW        = 24,
    parameter int          BSRAM_AW      = 20,
    parameter logic [15:0] NO_TURBO_MASK = NO_TURBO_MASK_DEF
) (
    input  logic                       i_mclk,
    input  logic                       i_rst,
    input  logic [NUM_CH-1:0]          i_map_active,
    input  logic [NUM_CH*8-1:0]        i_ch_do,
    input  logic [NUM_CH-1:0]          i_ch_irq_n,
    input  logic [NUM_CH*ROM_AW-1:0]   i_ch_rom_addr,
    input  logic [NUM_CH*16-1:0]       i_ch_rom_d,
    input  logic [NUM_CH-1:0]          i_ch_rom_ce_n,
    input  logic [NUM_CH-1:0]          i_ch_rom_oe_n,
    input  logic [NUM_CH-1:0]          i_ch_rom_we_n,
    input  logic [NUM_CH-1:0]          i_ch_rom_word,
    input  logic [NUM_CH*BSRAM_AW-1:0] i_ch_bsram_addr,
    input  logic [NUM_CH*8-1:0]        i_ch_bsram_d,
    input  logic [NUM_CH-1:0]          i_ch_bsram_ce_n,
    input  logic [NUM_CH-1:0]          i_ch_bsram_oe_n,
    input  logic [NUM_CH-1:0]          i_ch_bsram_we_n,
    output logic [7:0]                 o_di,
    output logic                       o_irq_n,
    output logic [ROM_AW-1:0]          o_rom_addr,
    output logic [15:0]                o_rom_d,
    output logic                       o_rom_ce_n,
    output logic                       o_rom_oe_n,
    output logic                       o_rom_we_n,
    output logic                       o_rom_word,
    output logic [BSRAM_AW-1:0]        o_bsram_addr,
    output logic [7:0]                 o_bsram_d,
    output logic                       o_bsram_ce_n,
    output logic                       o_bsram_oe_n,
    output logic                       o_bsram_we_n,
    output logic [3:0]                 o_sel,
    output logic                       o_locked,
    output logic                       o_turbo_allow,
    output logic                       o_map_err
);

    generate
        if (NUM_CH < 2 || NUM_CH > 16 || DEFAULT_CH < 0 || DEFAULT_CH >= NUM_CH ||
            SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_cfg
            $error("cart_map_arbiter: illegal NUM_CH/DEFAULT_CH/SETTLE_CYCLES");
        end
    endgenerate

    localparam logic [3:0] DEF_IDX = 4'(DEFAULT_CH);
    localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYCLES - 1);

    cart_map_state_e   r_state, w_state_nx;
    logic [NUM_CH-1:0] r_cand, w_cand_nx;
    logic [7:0]        r_cnt, w_cnt_nx;
    logic [3:0]        r_ch, w_ch_nx;
    logic              r_locked, w_locked_nx;
    logic              w_lock_entry;

    logic [3:0] w_dec_idx;
    logic       w_dec_any, w_dec_multi;
    logic [3:0] w_dec_ch;
    logic       w_bus_idle;

    cart_map_onehot_dec #(.NUM_CH(NUM_CH)) u_dec (
        .i_vec   (r_cand),
        .o_idx   (w_dec_idx),
        .o_any   (w_dec_any),
        .o_multi (w_dec_multi)
    );

    assign w_dec_ch   = (w_dec_any && !w_dec_multi) ? w_dec_idx : DEF_IDX;
    assign w_bus_idle = i_ch_rom_ce_n[r_ch] & i_ch_bsram_ce_n[r_ch];

    always_comb begin
        w_state_nx   = r_state;
        w_cand_nx    = r_cand;
        w_cnt_nx     = r_cnt;
        w_ch_nx      = r_ch;
        w_locked_nx  = r_locked;
        w_lock_entry = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_cand_nx  = i_map_active;
                w_cnt_nx   = '0;
                w_state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (i_map_active != r_cand) begin
                    w_cand_nx = i_map_active;
                    w_cnt_nx  = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nx   = ST_LOCKED;
                    w_ch_nx      = w_dec_ch;
                    w_locked_nx  = 1'b1;
                    w_lock_entry = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (i_map_active != r_cand) w_state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // A returning request wins over draining, so there is no idle gap.
                if (i_map_active == r_cand) begin
                    w_state_nx = ST_LOCKED;
                end else if (w_bus_idle) begin
                    w_locked_nx = 1'b0;
                    w_cand_nx   = i_map_active;
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_SETTLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            r_state  <= ST_BOOT;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_ch     <= DEF_IDX;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cand   <= w_cand_nx;
            r_cnt    <= w_cnt_nx;
            r_ch     <= w_ch_nx;
            r_locked <= w_locked_nx;
        end
    end

    assign o_locked = r_locked;

    // Outputs are loaded from the channel chosen for the next cycle, keeping data aligned with locked.
    always_ff @(posedge i_mclk) begin
        if (i_rst || !w_locked_nx) begin
            o_di          <= '0;
            o_irq_n       <= 1'b1;
            o_rom_addr    <= '0;
            o_rom_d       <= '0;
            o_rom_ce_n    <= 1'b1;
            o_rom_oe_n    <= 1'b1;
            o_rom_we_n    <= 1'b1;
            o_rom_word    <= 1'b0;
            o_bsram_addr  <= '0;
            o_bsram_d     <= '0;
            o_bsram_ce_n  <= 1'b1;
            o_bsram_oe_n  <= 1'b1;
            o_bsram_we_n  <= 1'b1;
            o_sel         <= DEF_IDX;
            o_turbo_allow <= 1'b1;
        end else begin
            o_di          <= i_ch_do[w_ch_nx*8 +: 8];
            o_irq_n       <= i_ch_irq_n[w_ch_nx];
            o_rom_addr    <= i_ch_rom_addr[w_ch_nx*ROM_AW +: ROM_AW];
            o_rom_d       <= i_ch_rom_d[w_ch_nx*16 +: 16];
            o_rom_ce_n    <= i_ch_rom_ce_n[w_ch_nx];
            o_rom_oe_n    <= i_ch_rom_oe_n[w_ch_nx];
            o_rom_we_n    <= i_ch_rom_we_n[w_ch_nx];
            o_rom_word    <= i_ch_rom_word[w_ch_nx];
            o_bsram_addr  <= i_ch_bsram_addr[w_ch_nx*BSRAM_AW +: BSRAM_AW];
            o_bsram_d     <= i_ch_bsram_d[w_ch_nx*8 +: 8];
            o_bsram_ce_n  <= i_ch_bsram_ce_n[w_ch_nx];
            o_bsram_oe_n  <= i_ch_bsram_oe_n[w_ch_nx];
            o_bsram_we_n  <= i_ch_bsram_we_n[w_ch_nx];
            o_sel         <= w_ch_nx;
            o_turbo_allow <= ~NO_TURBO_MASK[w_ch_nx];
        end
    end

`ifdef CART_MAP_ERR_EN
    logic r_map_err;
    logic w_err_set;

    // Fallback selection is only an error when the candidate does not itself request the default channel.
    assign w_err_set = w_lock_entry && !(w_dec_any && !w_dec_multi) && !r_cand[DEFAULT_CH];

    always_ff @(posedge i_mclk) begin
        if (i_rst)          r_map_err <= 1'b0;
        else if (w_err_set) r_map_err <= 1'b1;
    end

    assign o_map_err = r_map_err;
`else
    logic w_unused_lock_entry;
    assign w_unused_lock_entry = w_lock_entry;
    assign o_map_err = 1'b0;
`endif

endmodule
